id_ex_hazard_stage: RTL

ID/EX pipeline register with integrated load-use hazard detection and branch-flush control.
- Captures decoded operands and control from ID and presents them to EX, including the forwarding unit's EX_rs / EX_rt / EX_MemWrite / EX_AluSrc2 inputs.
- Drives PC and IF/ID write-enables and inserts bubbles.
- Owns the stall/flush/freeze sequencing for the 5-stage core.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/load_use_detect.sv | 24 ++
 rtl/id_ex_hazard_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: default operand/ALU widths, the hazard-stage state encoding
// and the ID/EX control bundle with its bubble value.
package pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [0:0] hz_state_t;
  localparam hz_state_t RUN   = 1'b0;
  localparam hz_state_t FLUSH = 1'b1;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src2;
    logic [ALUOP_W-1:0] alu_op;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the
// instruction in ID. Kept standalone so an IF/ID-side detector can reuse it.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_write_reg,
  output logic       load_use
);

  logic hit_rs;
  logic hit_rt;

  assign hit_rs   = (ex_write_reg == id_rs);
  assign hit_rt   = id_uses_rt & (ex_write_reg == id_rt);
  assign load_use = id_valid & ex_valid & ex_mem_read &
                    (ex_write_reg != REG_ZERO) & (hit_rs | hit_rt);

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, branch-flush and memory-freeze sequencing.
// Optional HAZARD_PERF_CNT_EN adds saturating LoadUseStalls / FlushBubbles counters.
module id_ex_hazard_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W       = pipe_pkg::DATA_W,
  parameter int ALUOP_W      = pipe_pkg::ALUOP_W,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               ID_Valid,
  input  logic [4:0]         ID_rs,
  input  logic [4:0]         ID_rt,
  input  logic [4:0]         ID_rd,
  input  logic               ID_UsesRt,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_AluSrc2,
  input  logic               ID_RegDst,
  input  logic [ALUOP_W-1:0] ID_AluOp,
  input  logic               Branch_Taken,
  input  logic               MemFreeze,
  output logic               EX_Valid,
  output logic [4:0]         EX_rs,
  output logic [4:0]         EX_rt,
  output logic [4:0]         EX_WriteRegister,
  output logic [DATA_W-1:0]  EX_ReadData1,
  output logic [DATA_W-1:0]  EX_ReadData2,
  output logic [DATA_W-1:0]  EX_Imm,
  output logic               EX_RegWrite,
  output logic               EX_MemRead,
  output logic               EX_MemWrite,
  output logic               EX_AluSrc2,
  output logic [ALUOP_W-1:0] EX_AluOp,
  output logic               PCWrite,
  output logic               IFID_Write,
  output logic               IFID_Flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]        LoadUseStalls,
  output logic [31:0]        FlushBubbles
`endif
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  hz_state_t   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pending_q, pending_d;

  logic              ex_valid_q, ex_valid_d;
  logic [4:0]        ex_rs_q, ex_rs_d;
  logic [4:0]        ex_rt_q, ex_rt_d;
  logic [4:0]        ex_wr_q, ex_wr_d;
  logic [DATA_W-1:0] ex_rd1_q, ex_rd1_d;
  logic [DATA_W-1:0] ex_rd2_q, ex_rd2_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  id_ex_ctrl_t       ex_ctrl_q, ex_ctrl_d;
  id_ex_ctrl_t       id_ctrl;

  logic load_use;
  logic pc_write, ifid_write, ifid_flush;
  logic load_id, lu_bubble, flush_bubble;

  load_use_detect u_lu (
    .id_valid     (ID_Valid),
    .id_rs        (ID_rs),
    .id_rt        (ID_rt),
    .id_uses_rt   (ID_UsesRt),
    .ex_valid     (ex_valid_q),
    .ex_mem_read  (ex_ctrl_q.mem_read),
    .ex_write_reg (ex_wr_q),
    .load_use     (load_use)
  );

  assign id_ctrl = '{reg_write: ID_RegWrite, mem_read: ID_MemRead,
                     mem_write: ID_MemWrite, alu_src2: ID_AluSrc2, alu_op: ID_AluOp};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    load_id      = 1'b0;
    lu_bubble    = 1'b0;
    flush_bubble = 1'b0;

    if (MemFreeze) begin
      // Whole pipe holds; a branch seen now is replayed on the first unfrozen cycle.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pending_d  = pending_q | Branch_Taken;
    end else begin
      pending_d = 1'b0;
      if (Branch_Taken | pending_q) begin
        ifid_flush   = 1'b1;
        flush_bubble = 1'b1;
        cnt_d        = CNT_LOAD;
        state_d      = (CNT_LOAD != 3'd0) ? FLUSH : RUN;
      end else if (state_q == FLUSH) begin
        ifid_flush   = 1'b1;
        flush_bubble = 1'b1;
        cnt_d        = cnt_q - 3'd1;
        state_d      = (cnt_d == 3'd0) ? RUN : FLUSH;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        lu_bubble  = 1'b1;
      end else begin
        load_id = 1'b1;
      end
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    ex_wr_d    = ex_wr_q;
    ex_rd1_d   = ex_rd1_q;
    ex_rd2_d   = ex_rd2_q;
    ex_imm_d   = ex_imm_q;
    ex_ctrl_d  = ex_ctrl_q;
    if (load_id) begin
      ex_valid_d = ID_Valid;
      ex_rs_d    = ID_rs;
      ex_rt_d    = ID_rt;
      ex_wr_d    = ID_RegDst ? ID_rd : ID_rt;
      ex_rd1_d   = ID_ReadData1;
      ex_rd2_d   = ID_ReadData2;
      ex_imm_d   = ID_Imm;
      ex_ctrl_d  = id_ctrl;
    end else if (lu_bubble | flush_bubble) begin
      ex_valid_d = 1'b0;
      ex_rs_d    = REG_ZERO;
      ex_rt_d    = REG_ZERO;
      ex_wr_d    = REG_ZERO;
      ex_rd1_d   = '0;
      ex_rd2_d   = '0;
      ex_imm_d   = '0;
      ex_ctrl_d  = CTRL_BUBBLE;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= RUN;
      cnt_q      <= 3'd0;
      pending_q  <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_rs_q    <= REG_ZERO;
      ex_rt_q    <= REG_ZERO;
      ex_wr_q    <= REG_ZERO;
      ex_rd1_q   <= '0;
      ex_rd2_q   <= '0;
      ex_imm_q   <= '0;
      ex_ctrl_q  <= CTRL_BUBBLE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      ex_valid_q <= ex_valid_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_wr_q    <= ex_wr_d;
      ex_rd1_q   <= ex_rd1_d;
      ex_rd2_q   <= ex_rd2_d;
      ex_imm_q   <= ex_imm_d;
      ex_ctrl_q  <= ex_ctrl_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic [31:0] fb_cnt_q, fb_cnt_d;

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    fb_cnt_d = fb_cnt_q;
    if (lu_bubble && (lu_cnt_q != '1)) lu_cnt_d = lu_cnt_q + 32'd1;
    if (flush_bubble && (fb_cnt_q != '1)) fb_cnt_d = fb_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lu_cnt_q <= '0;
      fb_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      fb_cnt_q <= fb_cnt_d;
    end
  end

  assign LoadUseStalls = lu_cnt_q;
  assign FlushBubbles  = fb_cnt_q;
`endif

  // Reset forces the fetch-side controls to their free-running values.
  assign PCWrite    = Reset | pc_write;
  assign IFID_Write = Reset | ifid_write;
  assign IFID_Flush = ~Reset & ifid_flush;

  assign EX_Valid         = ex_valid_q;
  assign EX_rs            = ex_rs_q;
  assign EX_rt            = ex_rt_q;
  assign EX_WriteRegister = ex_wr_q;
  assign EX_ReadData1     = ex_rd1_q;
  assign EX_ReadData2     = ex_rd2_q;
  assign EX_Imm           = ex_imm_q;
  assign EX_RegWrite      = ex_ctrl_q.reg_write;
  assign EX_MemRead       = ex_ctrl_q.mem_read;
  assign EX_MemWrite      = ex_ctrl_q.mem_write;
  assign EX_AluSrc2       = ex_ctrl_q.alu_src2;
  assign EX_AluOp         = ex_ctrl_q.alu_op;

endmodule
